srsystem_uart_rx: RTL and testbench

Parametrised next-generation serial reception system. It performs oversampled asynchronous frame reception with configurable data width, parity mode and stop-bit checking. Received words go into an internal show-ahead FIFO, so several frames can arrive before the host acknowledges. Error reporting is sticky and per cause. It replaces the single-word latch/ack receiver; the host side keeps the DRY/ack/Q handshake.

---
 rtl/srsystem_uart_rx.sv | 174 +++++++++++++++++
 tb/tb_srsystem_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/srsystem_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// srsystem_uart_rx : oversampled UART receiver with show-ahead FIFO and
//                    sticky per-cause error flags.  Rev 1.0
// ---------------------------------------------------------------------------
module srsystem_uart_rx #(
  parameter int DW       = 8,
  parameter int PAR_MODE = 1,
  parameter int OVS      = 16,
  parameter int DIV      = 4,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rx,
  input  logic          ack,
  input  logic          clr,
  output logic          DRY,
  output logic [DW-1:0] Q,
  output logic          ERR,
  output logic [2:0]    FLAGS
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DW);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t        state;
  logic          rs_meta, rs, rs_d;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] s_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic          perr;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic tick, counting, sample, stop_smp;
  logic push, pop, full, wr, ovr, set_par, set_frm;

  always_comb begin
    tick     = (tick_cnt == TW'(DIV - 1));
    counting = (state == S_START) || (state == S_DATA) ||
               (state == S_PARITY) || (state == S_STOP);
    sample   = counting && en && tick &&
               (s_cnt == ((state == S_START) ? SW'(OVS / 2 - 1) : SW'(OVS - 1)));
    stop_smp = sample && (state == S_STOP);
    push     = stop_smp && rs && !perr;
    set_par  = stop_smp && rs && perr;
    set_frm  = stop_smp && !rs;
    pop      = ack && (count != '0);
    full     = (count == CW'(DEPTH));
    wr       = push && (!full || pop);
    ovr      = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
      rs_d    <= 1'b1;
    end else begin
      rs_meta <= rx;
      rs      <= rs_meta;
      rs_d    <= rs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
    end else if (state != S_IDLE && !en) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      s_cnt    <= '0;
    end else begin
      tick_cnt <= (state == S_IDLE || tick) ? '0 : tick_cnt + 1'b1;
      if (counting && tick)
        s_cnt <= sample ? '0 : s_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (en && rs_d && !rs) begin
            state    <= S_START;
            tick_cnt <= '0;
            s_cnt    <= '0;
            perr     <= 1'b0;
          end
        end
        S_START: begin
          if (sample) begin
            state   <= rs ? S_IDLE : S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (sample) begin
            shreg <= {rs, shreg[DW-1:1]};
            if (bit_cnt == BW'(DW - 1))
              state <= (PAR_MODE != 0) ? S_PARITY : S_STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          // Even mode expects XOR of data and parity bit to be 0, odd mode 1.
          if (sample) begin
            perr  <= ((^shreg) ^ rs) != (PAR_MODE == 2);
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample)
            state <= rs ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rs)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  // A set event in the same cycle as clr takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      FLAGS <= 3'b000;
    else
      FLAGS <= (clr ? 3'b000 : FLAGS) | {ovr, set_frm, set_par};
  end

  assign DRY = (count != '0);
  assign Q   = mem[rd_ptr];
  assign ERR = |FLAGS;

endmodule
`default_nettype wire

// File: tb/tb_srsystem_uart_rx.sv
`default_nettype none
// tb_srsystem_uart_rx : randomized frames against a frame-level reference
// model, plus directed scenarios with literal expectations.
module tb_srsystem_uart_rx;

  localparam int DW       = 8;
  localparam int PAR_MODE = 1;
  localparam int OVS      = 4;
  localparam int DIV      = 2;
  localparam int DEPTH    = 4;
  localparam int BIT      = OVS * DIV;

  logic          clk = 1'b0;
  logic          rst, en, rx, ack, clr;
  logic          DRY;
  logic [DW-1:0] Q;
  logic          ERR;
  logic [2:0]    FLAGS;

  int   vectors = 0;
  int   errors  = 0;
  bit   quiet   = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [2:0]    exp_flags = 3'b000;

  always #5 clk = ~clk;

  srsystem_uart_rx #(
    .DW(DW), .PAR_MODE(PAR_MODE), .OVS(OVS), .DIV(DIV), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx), .ack(ack), .clr(clr),
    .DRY(DRY), .Q(Q), .ERR(ERR), .FLAGS(FLAGS)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level outcome: framing beats parity; a good word overruns a full FIFO.
  task automatic model_frame(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop);
    if (bad_stop)                     exp_flags[1] = 1'b1;
    else if (bad_par)                 exp_flags[0] = 1'b1;
    else if (exp_q.size() == DEPTH)   exp_flags[2] = 1'b1;
    else                              exp_q.push_back(d);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop,
                      input int abort_bit, input int hold);
    logic [DW+2:0] bits;
    logic          par;
    quiet = 1'b0;
    par   = (($countones(d) % 2) != 0) ^ bad_par;
    bits  = {~bad_stop, par, d, 1'b0};
    for (int i = 0; i < DW + 3; i++) begin
      if (i == abort_bit) en = 1'b0;
      rx = bits[i];
      wait_clk(BIT);
    end
    if (bad_stop) begin
      wait_clk(hold);
      rx = 1'b1;
    end
    wait_clk(2 * BIT);
    if (abort_bit >= 0) begin
      en = 1'b1;
      wait_clk(2);
    end else begin
      model_frame(d, bad_par, bad_stop);
    end
    quiet = 1'b1;
  endtask

  task automatic send_ok(input logic [DW-1:0] d);
    send(d, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic pop();
    ack = 1'b1;
    wait_clk(1);
    ack = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_clr();
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    exp_flags = 3'b000;
  endtask

  always @(negedge clk) begin
    if (quiet && rst) begin
      check("dry", {15'd0, DRY}, {15'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("q_head", {8'd0, Q}, {8'd0, exp_q[0]});
      check("flags", {13'd0, FLAGS}, {13'd0, exp_flags});
      check("err", {15'd0, ERR}, {15'd0, |exp_flags});
    end
  end

  int            kind, ab, npop;
  bit            bp, bs;
  logic [DW-1:0] rd;

  initial begin
    rst = 1'b0; en = 1'b1; rx = 1'b1; ack = 1'b0; clr = 1'b0;
    wait_clk(3);
    check("rst_dry", {15'd0, DRY}, 16'h0);
    check("rst_q", {8'd0, Q}, 16'h0);
    check("rst_flags", {13'd0, FLAGS}, 16'h0);
    check("rst_err", {15'd0, ERR}, 16'h0);
    rst = 1'b1;
    wait_clk(4);
    quiet = 1'b1;

    send_ok(8'hA5);
    check("a5_dry", {15'd0, DRY}, 16'h1);
    check("a5_q", {8'd0, Q}, 16'h00A5);
    check("a5_flags", {13'd0, FLAGS}, 16'h0);
    pop();
    check("a5_dry_after_ack", {15'd0, DRY}, 16'h0);

    send(8'h3C, 1'b1, 1'b0, -1, 0);
    check("par_flags", {13'd0, FLAGS}, 16'h1);
    check("par_err", {15'd0, ERR}, 16'h1);
    check("par_dry", {15'd0, DRY}, 16'h0);
    do_clr();
    wait_clk(1);
    check("clr_flags", {13'd0, FLAGS}, 16'h0);

    send(8'h81, 1'b0, 1'b1, -1, 40 - BIT);
    check("brk_flags", {13'd0, FLAGS}, 16'h2);
    check("brk_dry", {15'd0, DRY}, 16'h0);
    send_ok(8'h7E);
    check("after_brk_q", {8'd0, Q}, 16'h007E);
    pop();
    do_clr();

    for (int i = 1; i <= 5; i++) send_ok(DW'(i));
    check("ovr_flags", {13'd0, FLAGS}, 16'h4);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_order", {8'd0, Q}, 16'(i));
      pop();
    end
    check("ovr_drained", {15'd0, DRY}, 16'h0);
    do_clr();

    rx = 1'b0;
    wait_clk(2);
    rx = 1'b1;
    wait_clk(4 * BIT);
    check("glitch_dry", {15'd0, DRY}, 16'h0);
    check("glitch_flags", {13'd0, FLAGS}, 16'h0);
    send(8'h55, 1'b0, 1'b0, 5, 0);
    check("abort_dry", {15'd0, DRY}, 16'h0);
    send_ok(8'h55);
    check("reen_q", {8'd0, Q}, 16'h0055);

    send_ok(8'h11);
    send(8'h33, 1'b1, 1'b0, -1, 0);
    quiet = 1'b0;
    rx = 1'b0;
    wait_clk(30);
    #3 rst = 1'b0;
    #1;
    check("arst_dry", {15'd0, DRY}, 16'h0);
    check("arst_flags", {13'd0, FLAGS}, 16'h0);
    check("arst_q", {8'd0, Q}, 16'h0);
    rx = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    exp_q.delete();
    exp_flags = 3'b000;
    wait_clk(2 * BIT);
    quiet = 1'b1;
    send_ok(8'hF0);
    check("post_rst_q", {8'd0, Q}, 16'h00F0);
    pop();

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      rd   = DW'($urandom);
      bp   = (kind == 7 || kind == 8);
      bs   = (kind == 9);
      ab   = (kind == 6) ? $urandom_range(1, 9) : -1;
      send(rd, bp, bs, ab, $urandom_range(BIT, 4 * BIT));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop();
      if ($urandom_range(0, 7) == 0) do_clr();
      wait_clk($urandom_range(0, 5));
    end
    while (exp_q.size() > 0) pop();
    wait_clk(2);
    quiet = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
